// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiter and its picker.
package uart_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned GUARD_DEF = 8;
    localparam int unsigned IDW       = $clog2(NREQ_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping modulo NREQ.
module uart_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one transmit_engine between NREQ byte sources.
// Optional UART_TX_ARB_PRIORITY_EN: requester 0 becomes strict priority over the round-robin group.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned GUARD = GUARD_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [8*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]          req_ack,
    input  logic                     txrdy,
    output logic [7:0]               out_port,
    output logic                     load,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     stall
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam int unsigned GCNT_W = $clog2(GUARD + 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NREQ - 1);

    arb_state_e        state_q, state_d;
    logic [GCNT_W-1:0] guard_q, guard_d;
    logic [7:0]        out_port_d;
    logic              load_d, busy_d, stall_d;
    logic [NREQ-1:0]   req_ack_d;
    logic [ID_W-1:0]   grant_id_d;

    logic [NREQ-1:0]   pick_req;
    logic [ID_W-1:0]   rr_last, pick_winner, winner;
    logic              pick_found, found;

`ifdef UART_TX_ARB_PRIORITY_EN
    // Separate round-robin pointer so grants to requester 0 leave the rotation untouched.
    logic [ID_W-1:0] rr_q, rr_d;

    assign pick_req = req_valid & ~NREQ'(1);
    assign rr_last  = rr_q;
    assign winner   = req_valid[0] ? '0 : pick_winner;
    assign found    = req_valid[0] | pick_found;

    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && txrdy && found && winner != '0) begin
            rr_d = winner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= ID_LAST;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign pick_req = req_valid;
    assign rr_last  = grant_id;
    assign winner   = pick_winner;
    assign found    = pick_found;
`endif

    uart_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (pick_req),
        .last   (rr_last),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        out_port_d = out_port;
        grant_id_d = grant_id;
        load_d     = 1'b0;
        req_ack_d  = '0;
        stall_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (txrdy && found) begin
                    out_port_d        = req_data[32'(winner)*8 +: 8];
                    grant_id_d        = winner;
                    req_ack_d[winner] = 1'b1;
                    load_d            = 1'b1;
                    state_d           = LOAD;
                end
            end
            LOAD: begin
                guard_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!txrdy) begin
                    state_d = WAIT_DONE;
                end else if (guard_q == GCNT_W'(GUARD - 1)) begin
                    // Engine never took the byte: drop the frame rather than retry.
                    stall_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + GCNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (txrdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            guard_q  <= '0;
            out_port <= '0;
            load     <= 1'b0;
            req_ack  <= '0;
            grant_id <= ID_LAST;
            busy     <= 1'b0;
            stall    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            out_port <= out_port_d;
            load     <= load_d;
            req_ack  <= req_ack_d;
            grant_id <= grant_id_d;
            busy     <= busy_d;
            stall    <= stall_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a transmit-engine model and grant-order reference.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int GUARD = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              txrdy;
    logic [7:0]        out_port;
    logic              load;
    logic [1:0]        grant_id;
    logic              busy;
    logic              stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic eng_on;
    int   eng_busy;
    int   m_last, m_rr;

    uart_tx_arbiter #(.NREQ(NREQ), .GUARD(GUARD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .txrdy     (txrdy),
        .out_port  (out_port),
        .load      (load),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: goes busy the cycle after a load, stays busy eng_busy cycles.
    initial begin : engine
        int n;
        forever begin
            @(negedge clk);
            if (eng_on && load === 1'b1) begin
                n = eng_busy;
                @(negedge clk);
                txrdy = 1'b0;
                repeat (n) @(negedge clk);
                txrdy = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_last = NREQ - 1;
        m_rr   = NREQ - 1;
    endfunction

    // Next winner: first pending index after the last one served, wrapping around.
    function automatic int model_pick(input logic [NREQ-1:0] p);
`ifdef UART_TX_ARB_PRIORITY_EN
        if (p[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (i != 0 && p[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic void model_update(input int w);
        m_last = w;
        if (w != 0) m_rr = w;
    endfunction

    task automatic expect_grant(input int budget, input string tag, output int w, output int lcyc);
        logic [NREQ-1:0] pend;
        logic            got;
        logic [7:0]      eb;
        pend = req_valid;
        w    = model_pick(pend);
        got  = 1'b0;
        lcyc = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (load === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_load"}, 32'(got), 32'd1);
        if (got) begin
            lcyc = cyc;
            if (w < 0) begin
                check({tag, "_unexpected_ack"}, 32'(req_ack), 32'd0);
            end else begin
                eb = req_data[8*w +: 8];
                check({tag, "_grant_id"}, 32'(grant_id), 32'(w));
                check({tag, "_out_port"}, 32'(out_port), 32'(eb));
                check({tag, "_ack"}, 32'(req_ack), 32'(1 << w));
                model_update(w);
                req_valid[w] = 1'b0;
            end
            @(negedge clk);
            check({tag, "_load_pulse"}, 32'(load), 32'd0);
            check({tag, "_ack_pulse"}, 32'(req_ack), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(got), 32'd1);
    endtask

    task automatic set_bytes(input logic [7:0] base);
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = base + 8'(i);
    endtask

    initial begin : main
        int w, lc, prev, bad;
        logic got;
        logic [NREQ-1:0] m;

        reset = 1'b0; req_valid = '0; req_data = '0; txrdy = 1'b1;
        eng_on = 1'b1; eng_busy = 5;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single requester, one-cycle latency
        req_data[7:0] = 8'h0F; req_valid = 4'b0001;
        expect_grant(1, "t1", w, lc);
        check("t1_byte", 32'(out_port), 32'h0F);
        wait_idle(50, "t1");

        // All four requesting, long frames
        reset = 1'b0; @(negedge clk); reset = 1'b1; model_reset(); @(negedge clk);
        eng_busy = 100; set_bytes(8'hA0); req_valid = 4'b1111;
        prev = 0;
        for (int f = 0; f < 5; f++) begin
            expect_grant(200, "t2", w, lc);
            check("t2_order", 32'(grant_id), 32'(f % 4));
            if (f > 0) check("t2_spacing", 32'((lc - prev) >= 103), 32'd1);
            prev = lc;
            if (w >= 0) req_valid[w] = 1'b1;
        end
        req_valid = '0;
        wait_idle(200, "t2");

        // Dead engine: stall 9 cycles after load
        eng_on = 1'b0; txrdy = 1'b1;
        req_data[23:16] = 8'h5A; req_valid = 4'b0100;
        expect_grant(5, "t3", w, lc);
        check("t3_gid", 32'(grant_id), 32'd2);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall === 1'b1) begin got = 1'b1; break; end
        end
        check("t3_stall_seen", 32'(got), 32'd1);
        check("t3_stall_delay", 32'(cyc - lc), 32'd9);
        check("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t3_stall_pulse", 32'(stall), 32'd0);

        // Engine not ready: no grant until txrdy rises
        txrdy = 1'b0; eng_busy = 5;
        req_data[15:8] = 8'h3C; req_valid = 4'b0010;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (load !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b0) bad++;
        end
        check("t4_hold", 32'(bad), 32'd0);
        eng_on = 1'b1; txrdy = 1'b1;
        expect_grant(1, "t4", w, lc);
        check("t4_gid", 32'(grant_id), 32'd1);
        wait_idle(50, "t4");

        // Async reset mid-frame
        eng_busy = 50;
        req_data[31:24] = 8'hC3; req_valid = 4'b1000;
        expect_grant(5, "t5", w, lc);
        repeat (4) @(negedge clk);
        check("t5_in_frame", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_load", 32'(load), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_gid", 32'(grant_id), 32'd3);
        check("t5_rst_ack", 32'(req_ack), 32'd0);
        check("t5_rst_out", 32'(out_port), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        set_bytes(8'hB0); req_valid = 4'b1111;
        expect_grant(120, "t5_post", w, lc);
        check("t5_first", 32'(grant_id), 32'd0);
        req_valid = '0;
        wait_idle(200, "t5");

        // Randomized traffic against the reference
        for (int it = 0; it < 30; it++) begin
            eng_busy = $urandom_range(1, 20);
            if ($urandom_range(0, 3) == 0) req_valid &= 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (m[i] && !req_valid[i]) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                w = $urandom_range(0, NREQ - 1);
                req_data[8*w +: 8] = 8'($urandom);
                req_valid[w] = 1'b1;
            end
            expect_grant(60, "rnd", w, lc);
        end
        req_valid = '0;
        wait_idle(60, "rnd");

`ifdef UART_TX_ARB_PRIORITY_EN
        // Strict priority for requester 0
        reset = 1'b0; @(negedge clk); reset = 1'b1; model_reset(); @(negedge clk);
        eng_busy = 3; set_bytes(8'hD0); req_valid = 4'b0111;
        for (int f = 0; f < 3; f++) begin
            expect_grant(40, "pri0", w, lc);
            check("pri0_gid", 32'(grant_id), 32'd0);
            if (f < 2 && w >= 0) req_valid[w] = 1'b1;
        end
        for (int f = 0; f < 4; f++) begin
            expect_grant(40, "pri_rr", w, lc);
            check("pri_rr_gid", 32'(grant_id), (f % 2 == 0) ? 32'd1 : 32'd2);
            if (w >= 0) req_valid[w] = 1'b1;
        end
        req_valid = '0;
        wait_idle(60, "pri");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
